tbird_light_sequencer: RTL and testbench

- Controller that sequences the six Thunderbird tail lamps (three per side) for left turn, right turn and hazard.
- Contains its own tick divider: one sequencing step per TICK_DIV clock cycles.
- Sits between the user switch inputs and the lamp output pins.
- Arbitrates conflicting requests: hazard, or left and right together, beats a single turn request.

---
 rtl/tbird_light_sequencer.sv | 155 +++++++++++++++
 tb/tb_tbird_light_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tbird_light_sequencer.sv
// Thunderbird tail-lamp sequencer: left/right turn sweeps and hazard flash.
// It has a free-running tick divider, and all state changes happen only on
// divider steps.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   left/right     turn requests (level, already synchronised)
//   hazard         hazard request (level, already synchronised)
//   brake          brake input (only when TBIRD_BRAKE_EN is defined)
//   lights_l[2:0]  left lamps, bit0 innermost (registered)
//   lights_r[2:0]  right lamps, bit0 innermost (registered)
//   tick           one-cycle strobe per sequencing step (registered)
//   busy           high while not IDLE (registered)
//
// Optional feature: define TBIRD_BRAKE_EN to add the brake input. At a step,
// brake lights every side that is not sequencing. The hazard flash is left as it is.
module tbird_light_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
`ifdef TBIRD_BRAKE_EN
  input  logic       brake,
`endif
  output logic [2:0] lights_l,
  output logic [2:0] lights_r,
  output logic       tick,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_LR3  = 3'd7
  } state_t;

  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  state_t           r_state;
  logic [2:0]       r_lights_l;
  logic [2:0]       r_lights_r;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [2:0]       w_lights_l_nxt;
  logic [2:0]       w_lights_r_nxt;
  logic             w_step;
  logic             w_haz;
  logic             w_lreq;
  logic             w_rreq;
  logic             w_brake;

`ifdef TBIRD_BRAKE_EN
  assign w_brake = brake;
`else
  assign w_brake = 1'b0;
`endif

  // The step is the wrap cycle of the divider. The registered tick follows it by one cycle.
  assign w_step = (r_count == CNT_W'(TICK_DIV - 1));

  // Request arbitration: hazard, or both turns together, beats a single turn.
  assign w_haz  = hazard | (left & right);
  assign w_lreq = left & ~right & ~hazard;
  assign w_rreq = right & ~left & ~hazard;

  // Divider, state register, and step-aligned output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_state    <= ST_IDLE;
      r_lights_l <= 3'b000;
      r_lights_r <= 3'b000;
      r_busy     <= 1'b0;
    end else begin
      r_count <= w_step ? '0 : r_count + CNT_W'(1);
      r_tick  <= w_step;
      if (w_step) begin
        r_state    <= w_state_nxt;
        r_lights_l <= w_lights_l_nxt;
        r_lights_r <= w_lights_r_nxt;
        r_busy     <= (w_state_nxt != ST_IDLE);
      end
    end
  end

  // Next state and lamp pattern. These are only used on a step.
  always_comb begin
    w_state_nxt    = r_state;
    w_lights_l_nxt = 3'b000;
    w_lights_r_nxt = 3'b000;

    case (r_state)
      ST_IDLE: begin
        if (w_haz)       w_state_nxt = ST_LR3;
        else if (w_lreq) w_state_nxt = ST_L1;
        else if (w_rreq) w_state_nxt = ST_R1;
        else             w_state_nxt = ST_IDLE;
      end
      ST_L1:   w_state_nxt = w_haz ? ST_LR3 : (w_lreq ? ST_L2 : ST_IDLE);
      ST_L2:   w_state_nxt = w_haz ? ST_LR3 : (w_lreq ? ST_L3 : ST_IDLE);
      ST_L3:   w_state_nxt = w_haz ? ST_LR3 : ST_IDLE;
      ST_R1:   w_state_nxt = w_haz ? ST_LR3 : (w_rreq ? ST_R2 : ST_IDLE);
      ST_R2:   w_state_nxt = w_haz ? ST_LR3 : (w_rreq ? ST_R3 : ST_IDLE);
      ST_R3:   w_state_nxt = w_haz ? ST_LR3 : ST_IDLE;
      ST_LR3:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_L1:   w_lights_l_nxt = 3'b001;
      ST_L2:   w_lights_l_nxt = 3'b011;
      ST_L3:   w_lights_l_nxt = 3'b111;
      ST_R1:   w_lights_r_nxt = 3'b001;
      ST_R2:   w_lights_r_nxt = 3'b011;
      ST_R3:   w_lights_r_nxt = 3'b111;
      ST_LR3: begin
        w_lights_l_nxt = 3'b111;
        w_lights_r_nxt = 3'b111;
      end
      default: ;
    endcase

    // Brake fills the idle side. It is skipped on the half-period that follows LR3,
    // so the hazard flash stays visible.
    if (w_brake && (r_state != ST_LR3)) begin
      case (w_state_nxt)
        ST_IDLE: begin
          w_lights_l_nxt = 3'b111;
          w_lights_r_nxt = 3'b111;
        end
        ST_L1, ST_L2, ST_L3: w_lights_r_nxt = 3'b111;
        ST_R1, ST_R2, ST_R3: w_lights_l_nxt = 3'b111;
        default: ;
      endcase
    end
  end

  assign lights_l = r_lights_l;
  assign lights_r = r_lights_r;
  assign tick     = r_tick;
  assign busy     = r_busy;

endmodule

// File: tb/tb_tbird_light_sequencer.sv
// Randomised bench for tbird_light_sequencer. The reference model describes
// the lamps as a mode (idle/left/right/flash) plus a sweep position.
module tb_tbird_light_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CNT_W    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       left, right, hazard;
  logic       brake;
  logic [2:0] lights_l, lights_r;
  logic       tick, busy;

  always #5 clk = ~clk;

  tbird_light_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .left     (left),
    .right    (right),
    .hazard   (hazard),
`ifdef TBIRD_BRAKE_EN
    .brake    (brake),
`endif
    .lights_l (lights_l),
    .lights_r (lights_r),
    .tick     (tick),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 left sweep, 2 right sweep, 3 flash-on. pos is 1..3.
  int         m_mode, m_pos, m_k;
  logic [2:0] m_l, m_r;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_k = 0; m_l = 3'b000; m_r = 3'b000;
  endtask

  // Called at each rising edge, using the inputs that are stable at that edge.
  task automatic model_edge();
    bit haz, lreq, rreq, brk;
    int prev;
    m_k++;
    if (m_k % TICK_DIV == 0) begin
      haz  = hazard | (left & right);
      lreq = left & ~right & ~hazard;
      rreq = right & ~left & ~hazard;
`ifdef TBIRD_BRAKE_EN
      brk  = brake;
`else
      brk  = 1'b0;
`endif
      prev = m_mode;
      if (m_mode == 3)                   begin m_mode = 0; m_pos = 0; end
      else if (haz)                      begin m_mode = 3; m_pos = 3; end
      else if (m_mode == 0 && lreq)      begin m_mode = 1; m_pos = 1; end
      else if (m_mode == 0 && rreq)      begin m_mode = 2; m_pos = 1; end
      else if (m_mode == 1 && lreq && m_pos < 3) m_pos++;
      else if (m_mode == 2 && rreq && m_pos < 3) m_pos++;
      else                               begin m_mode = 0; m_pos = 0; end
      m_l = 3'((1 << ((m_mode == 1 || m_mode == 3) ? m_pos : 0)) - 1);
      m_r = 3'((1 << ((m_mode == 2 || m_mode == 3) ? m_pos : 0)) - 1);
      if (brk && prev != 3) begin
        if (m_mode != 1 && m_mode != 3) m_l = 3'b111;
        if (m_mode != 2 && m_mode != 3) m_r = 3'b111;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_eq("tick",     8'(tick),     8'(m_k > 0 && m_k % TICK_DIV == 0));
      check_eq("lights_l", 8'(lights_l), 8'(m_l));
      check_eq("lights_r", 8'(lights_r), 8'(m_r));
      check_eq("busy",     8'(busy),     8'(m_mode != 0));
    end
  endtask

  task automatic set_in(input bit l, input bit r, input bit h, input bit b);
    left = l; right = r; hazard = h; brake = b;
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_lights_l", 8'(lights_l), 8'h0);
    check_eq("rst_lights_r", 8'(lights_r), 8'h0);
    check_eq("rst_tick",     8'(tick),     8'h0);
    check_eq("rst_busy",     8'(busy),     8'h0);
    @(negedge clk);
    reset = 1'b0;

    // Idle, then a held left, then a held right with hazard raised in R2.
    run_cycles(20);
    set_in(1, 0, 0, 0); run_cycles(16);
    set_in(0, 0, 0, 0); run_cycles(4);
    set_in(0, 1, 0, 0); run_cycles(8);
    set_in(0, 1, 1, 0); run_cycles(16);
    // Left and right together behave like hazard. Dropping right leaves a left request.
    set_in(1, 1, 0, 0); run_cycles(12);
    set_in(1, 0, 0, 0); run_cycles(16);

    // Reset pulse in the middle of L2.
    set_in(0, 0, 0, 0); run_cycles(8);
    set_in(1, 0, 0, 0); run_cycles(9);
    reset = 1'b1;
    #1;
    check_eq("midrst_lights_l", 8'(lights_l), 8'h0);
    check_eq("midrst_busy",     8'(busy),     8'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_cycles(12);

`ifdef TBIRD_BRAKE_EN
    set_in(0, 0, 0, 0); run_cycles(8);
    set_in(1, 0, 0, 1); run_cycles(16);
    set_in(0, 0, 1, 1); run_cycles(12);
`endif

    // Random segments. Each level is held long enough to complete several steps.
    for (int s = 0; s < 60; s++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      run_cycles(int'($urandom_range(1, 24)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
